// File: rtl/bcd_display_driver.sv
// -----------------------------------------------------------------------------
// bcd_display_driver
//
// Purpose:
//   Converts a 14-bit binary count into four BCD digits with a sequential
//   double-dabble converter (one shift per clock, 14 clocks per conversion).
//   It then time-multiplexes the digits onto a shared seven-segment bus.
//   Values above 9999 are shown as "----".
//
// Parameters:
//   REFRESH_DIV   clocks each digit stays enabled (>= 2)
//   BLANK_LEADING 1 = blank leading zeros (the ones digit is never blanked)
//   ACTIVE_LOW    1 = segments and digit enables are asserted low
//
// Ports:
//   i_clock     system clock, all state changes on the rising edge
//   i_reset_n   asynchronous active-low reset
//   i_value     binary count to display
//   o_segments  {g,f,e,d,c,b,a} for the enabled digit (registered)
//   o_digit_en  one-hot digit enable, [0]=ones .. [3]=thousands (registered)
//   o_bcd       {thousands,hundreds,tens,ones} of the last conversion
//   o_overflow  last converted value was above 9999
//   o_busy      conversion in progress
// -----------------------------------------------------------------------------
module bcd_display_driver #(
  parameter int REFRESH_DIV   = 1000,
  parameter bit BLANK_LEADING = 1'b1,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [13:0] i_value,
  output logic [6:0]  o_segments,
  output logic [3:0]  o_digit_en,
  output logic [15:0] o_bcd,
  output logic        o_overflow,
  output logic        o_busy
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // ---------------------------------------------------------------------------
  // Converter
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  state_t      r_state;
  logic        r_first_pass;
  logic [13:0] r_last_value;
  logic [13:0] r_shift;
  logic [19:0] r_scratch;
  logic [3:0]  r_iter;
  logic [15:0] r_bcd;
  logic        r_overflow;
  logic        r_busy;

  logic [19:0] w_adj;
  logic [33:0] w_shifted;

  // Add-3 correction on every scratch nibble that would overflow past 9
  // after the following doubling.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5) ?
                                (r_scratch[gi*4 +: 4] + 4'd3) :
                                r_scratch[gi*4 +: 4];
    end
  endgenerate

  // One double-dabble step: the corrected scratch and the remaining binary
  // bits shift left together as one 34-bit word.
  assign w_shifted = {w_adj, r_shift} << 1;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_first_pass <= 1'b1;
      r_last_value <= '0;
      r_shift      <= '0;
      r_scratch    <= '0;
      r_iter       <= '0;
      r_bcd        <= '0;
      r_overflow   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_first_pass || (i_value != r_last_value)) begin
            r_shift      <= i_value;
            r_last_value <= i_value;
            r_scratch    <= '0;
            r_iter       <= '0;
            r_busy       <= 1'b1;
            r_first_pass <= 1'b0;
            r_state      <= S_CONV;
          end
        end
        S_CONV: begin
          r_scratch <= w_shifted[33:14];
          r_shift   <= w_shifted[13:0];
          r_iter    <= r_iter + 4'd1;
          if (r_iter == 4'd13) begin
            // The fifth digit is dropped; overflow tells the scanner to
            // show dashes instead.
            r_bcd      <= w_shifted[29:14];
            r_overflow <= (r_last_value > 14'd9999);
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_bcd      = r_bcd;
  assign o_overflow = r_overflow;
  assign o_busy     = r_busy;

  // ---------------------------------------------------------------------------
  // Refresh scanner
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_refresh_cnt;
  logic [1:0]       r_digit_idx;
  logic [6:0]       r_segments;
  logic [3:0]       r_digit_en;

  logic [3:0] w_digit [4];
  logic [3:0] w_lead_zero;
  logic [3:0] w_cur_digit;
  logic [6:0] w_seg;
  logic [3:0] w_onehot;

  // w_lead_zero[k]: digits k..3 are all zero, so digit k is a leading zero.
  // The ones digit is never treated as leading.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digits
      assign w_digit[gi] = r_bcd[gi*4 +: 4];
      if (gi == 0) begin : g_ones
        assign w_lead_zero[gi] = 1'b0;
      end else begin : g_upper
        assign w_lead_zero[gi] = (r_bcd[15:gi*4] == '0);
      end
    end
  endgenerate

  assign w_cur_digit = w_digit[r_digit_idx];
  assign w_onehot    = 4'b0001 << r_digit_idx;

  always_comb begin
    w_seg = 7'h00;
    if (r_overflow) begin
      w_seg = 7'h40;
    end else if (BLANK_LEADING && w_lead_zero[r_digit_idx]) begin
      w_seg = 7'h00;
    end else begin
      case (w_cur_digit)
        4'd0:    w_seg = 7'h3F;
        4'd1:    w_seg = 7'h06;
        4'd2:    w_seg = 7'h5B;
        4'd3:    w_seg = 7'h4F;
        4'd4:    w_seg = 7'h66;
        4'd5:    w_seg = 7'h6D;
        4'd6:    w_seg = 7'h7D;
        4'd7:    w_seg = 7'h07;
        4'd8:    w_seg = 7'h7F;
        4'd9:    w_seg = 7'h6F;
        default: w_seg = 7'h00;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= '0;
      r_segments    <= {7{ACTIVE_LOW}};
      r_digit_en    <= {4{ACTIVE_LOW}};
    end else begin
      if (r_refresh_cnt == CNT_MAX) begin
        r_refresh_cnt <= '0;
        r_digit_idx   <= r_digit_idx + 2'd1;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end
      r_segments <= ACTIVE_LOW ? ~w_seg : w_seg;
      r_digit_en <= ACTIVE_LOW ? ~w_onehot : w_onehot;
    end
  end

  assign o_segments = r_segments;
  assign o_digit_en = r_digit_en;

endmodule

// File: tb/tb_bcd_display_driver.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_driver
//
// Purpose:
//   Scoreboard bench for bcd_display_driver. Two instances share the inputs:
//   one blanks leading zeros and one does not. A reference process predicts
//   when each value is sampled and what it converts to, and pushes the
//   expected result. A monitor pops a result on each completed conversion and
//   checks the scanned display every cycle.
// -----------------------------------------------------------------------------
module tb_bcd_display_driver;

  logic        clk;
  logic        rst_n;
  logic [13:0] value;

  logic [6:0]  seg_a, seg_b;
  logic [3:0]  den_a, den_b;
  logic [15:0] bcd_a, bcd_b;
  logic        ovf_a, ovf_b;
  logic        busy_a, busy_b;

  bcd_display_driver #(
    .REFRESH_DIV  (4),
    .BLANK_LEADING(1'b1),
    .ACTIVE_LOW   (1'b0)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_value   (value),
    .o_segments(seg_a),
    .o_digit_en(den_a),
    .o_bcd     (bcd_a),
    .o_overflow(ovf_a),
    .o_busy    (busy_a)
  );

  bcd_display_driver #(
    .REFRESH_DIV  (4),
    .BLANK_LEADING(1'b0),
    .ACTIVE_LOW   (1'b0)
  ) dut_nb (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_value   (value),
    .o_segments(seg_b),
    .o_digit_en(den_b),
    .o_bcd     (bcd_b),
    .o_overflow(ovf_b),
    .o_busy    (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  int edge_n     = 0;
  bit first      = 1'b1;
  int last_val   = 0;
  int end_edge   = 0;
  int start_edge = -100;
  bit exp_busy   = 1'b0;

  // Monitor state
  int disp_val  = 0;
  bit prev_busy = 1'b0;
  int k;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)",
               name, act, exp_v, edge_n, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int w;
    w = v % 10000;
    return {4'(w / 1000), 4'((w / 100) % 10), 4'((w / 10) % 10), 4'(w % 10)};
  endfunction

  // Expected segment pattern for digit k of value v.
  function automatic logic [6:0] exp_seg(input int v, input bit blank_en, input int d);
    logic [6:0] tbl [10];
    int w;
    int p;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (v > 9999) return 7'h40;
    w = v % 10000;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (blank_en && (d >= 1) && ((w / p) == 0)) return 7'h00;
    return tbl[(w / p) % 10];
  endfunction

  // Reference model: the converter accepts a new value whenever it is free
  // and the input differs from the last accepted one; the result lands 14
  // edges later, and the next compare happens the edge after that.
  always @(posedge clk) begin
    if (!rst_n) begin
      edge_n     = 0;
      first      = 1'b1;
      end_edge   = 0;
      start_edge = -100;
      sb_q.delete();
    end else begin
      edge_n++;
      if ((edge_n > end_edge) && (first || (int'(value) != last_val))) begin
        first      = 1'b0;
        last_val   = int'(value);
        sb_q.push_back('{int'(value), edge_n + 14});
        start_edge = edge_n;
        end_edge   = edge_n + 14;
      end
    end
    exp_busy = rst_n && (edge_n >= start_edge) && (edge_n < start_edge + 14);
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst_n || edge_n == 0) begin
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_bcd", int'(bcd_a), 0);
      chk("rst_ovf", int'(ovf_a), 0);
      chk("rst_seg", int'(seg_a), 0);
      chk("rst_den", int'(den_a), 0);
      chk("rst_seg_nb", int'(seg_b), 0);
      disp_val  = 0;
      prev_busy = 1'b0;
    end else begin
      k = ((edge_n - 1) / 4) % 4;
      chk("digit_en", int'(den_a), 1 << k);
      chk("segments", int'(seg_a), int'(exp_seg(disp_val, 1'b1, k)));
      chk("segments_nb", int'(seg_b), int'(exp_seg(disp_val, 1'b0, k)));
      chk("busy", int'(busy_a), int'(exp_busy));
      if (prev_busy && !busy_a) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("bcd", int'(bcd_a), int'(to_bcd(e.val)));
          chk("overflow", int'(ovf_a), (e.val > 9999) ? 1 : 0);
          chk("latency_edge", edge_n, e.due);
          $display("conv value=%0d bcd=%04h ovf=%0d edge=%0d",
                   e.val, bcd_a, ovf_a, edge_n);
          disp_val = e.val;
        end
      end
      prev_busy = busy_a;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply(input int v, input int n);
    value = 14'(v);
    hold(n);
  endtask

  int rv;

  initial begin
    rst_n = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    hold(40);              // value 0 after reset
    apply(1234, 40);
    apply(9999, 30);
    apply(10000, 30);
    apply(16383, 30);
    apply(5, 3);           // change lands inside the conversion of 5
    apply(77, 40);
    apply(42, 40);

    apply(321, 5);         // reset in the middle of a conversion
    rst_n = 1'b0;
    hold(2);
    rst_n = 1'b1;
    hold(30);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1) rv = int'($urandom_range(0, 99));
      else                           rv = int'($urandom_range(0, 16383));
      apply(rv, int'($urandom_range(1, 30)));
    end
    hold(40);

    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
